// File: rtl/systolic_array_pkg.sv
// Shared types and default sizing for the systolic array tile scheduler.
// Scheduler state encoding and grid/reduction-depth defaults.
package systolic_array_pkg;

   localparam int SA_ARRAY_N = 4;
   localparam int SA_K_MAX   = 64;
   localparam int SA_SETTLE  = 2;

   typedef enum logic [2:0] {
      IDLE,
      FEED,
      SETTLE,
      DRAIN,
      DONE
   } sched_state_t;

endpackage

// File: rtl/sa_wavefront_scheduler_if.sv
// Tile-command, feeder, stall and result-walk signals of the scheduler.
// master = command/array side, slave = scheduler.
interface sa_wavefront_scheduler_if #(
   parameter int ARRAY_N = systolic_array_pkg::SA_ARRAY_N,
   parameter int K_MAX   = systolic_array_pkg::SA_K_MAX
);
   import systolic_array_pkg::*;

   localparam int KW = $clog2(K_MAX + 1);
   localparam int TW = $clog2(K_MAX + 2 * ARRAY_N);
   localparam int RW = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [KW-1:0]      cmd_k;
   logic               acc_clr;
   logic               feed_en;
   logic [TW-1:0]      feed_step;
   logic [ARRAY_N-1:0] row_start;
   logic [ARRAY_N-1:0] col_start;
   logic               pe_stall_any;
   logic               res_valid;
   logic               res_ready;
   logic [RW-1:0]      res_row;
   logic               busy;
   logic               done;
   logic [31:0]        perf_stall_cyc;

   modport master (
      output cmd_valid, cmd_k, pe_stall_any, res_ready,
      input  cmd_ready, acc_clr, feed_en, feed_step,
      input  row_start, col_start, res_valid, res_row,
      input  busy, done, perf_stall_cyc
   );

   modport slave (
      input  cmd_valid, cmd_k, pe_stall_any, res_ready,
      output cmd_ready, acc_clr, feed_en, feed_step,
      output row_start, col_start, res_valid, res_row,
      output busy, done, perf_stall_cyc
   );

endinterface

// File: rtl/sa_wavefront_scheduler_mask.sv
// Skewed input_start mask: lane i is active while i <= t < i+K.
// Pure combinational, one instance per feeder direction.
module sa_skew_mask #(
   parameter int ARRAY_N = systolic_array_pkg::SA_ARRAY_N,
   parameter int TW      = 7,
   parameter int KW      = 7
) (
   input  logic [TW-1:0]      t,
   input  logic [KW-1:0]      k,
   input  logic               en,
   output logic [ARRAY_N-1:0] mask
);
   import systolic_array_pkg::*;

   // One extra bit so i+K never wraps.
   localparam int EW = TW + 1;

   logic [EW-1:0] te;
   logic [EW-1:0] lo;
   logic [EW-1:0] hi;

   assign te = EW'(t);

   always_comb begin
      mask = '0;
      lo   = '0;
      hi   = '0;
      for (int i = 0; i < ARRAY_N; i++) begin
         lo      = EW'(i);
         hi      = lo + EW'(k);
         mask[i] = en && (te >= lo) && (te < hi);
      end
   end

endmodule

// File: rtl/sa_wavefront_scheduler.sv
// Wavefront scheduler: feeds one tile through the PE grid, settles, drains rows.
// Define SA_PERF_CNT_EN to enable the perf_stall_cyc stall counter.
module sa_wavefront_scheduler #(
   parameter int ARRAY_N = systolic_array_pkg::SA_ARRAY_N,
   parameter int K_MAX   = systolic_array_pkg::SA_K_MAX,
   parameter int SETTLE  = systolic_array_pkg::SA_SETTLE
) (
   input  logic                   clk,
   input  logic                   n_rst,
   sa_wavefront_scheduler_if.slave bus
);
   import systolic_array_pkg::*;

   localparam int KW    = $clog2(K_MAX + 1);
   localparam int TW    = $clog2(K_MAX + 2 * ARRAY_N);
   localparam int RW    = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
   localparam int SET_N = (SETTLE < 1) ? 1 : SETTLE;
   localparam int SW    = $clog2(SET_N + 1);

   localparam logic [KW-1:0] KMAX_V   = KW'(K_MAX);
   localparam logic [TW-1:0] SKEW     = TW'(2 * ARRAY_N - 2);
   localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_N - 1);
   localparam logic [SW-1:0] LAST_SET = SW'(SET_N - 1);

   sched_state_t  state, nxt;
   logic [TW-1:0] t_q, t_n;
   logic [KW-1:0] k_q, k_n;
   logic [SW-1:0] cnt_q, cnt_n;
   logic [RW-1:0] row_q, row_n;
   logic          ready_q;
   logic          busy_q;
   logic          done_q;
   logic          valid_q;

   logic          accept;
   logic          feed_en;
   logic [KW-1:0] k_in;
   logic [TW-1:0] last_t;

   always_comb begin
      accept  = (state == IDLE) && ready_q && bus.cmd_valid;
      feed_en = (state == FEED) && !bus.pe_stall_any;
      k_in    = (bus.cmd_k > KMAX_V) ? KMAX_V : bus.cmd_k;
      last_t  = TW'(k_q) + SKEW - TW'(1);
      nxt     = state;
      t_n     = t_q;
      k_n     = k_q;
      cnt_n   = cnt_q;
      row_n   = row_q;
      unique case (state)
         IDLE: begin
            if (accept) begin
               k_n = k_in;
               t_n = '0;
               nxt = (k_in == '0) ? DONE : FEED;
            end
         end
         FEED: begin
            if (feed_en) begin
               if (t_q == last_t) begin
                  nxt   = systolic_array_pkg::SETTLE;
                  cnt_n = '0;
               end else begin
                  t_n = t_q + TW'(1);
               end
            end
         end
         systolic_array_pkg::SETTLE: begin
            // Any stall restarts the quiet-cycle count.
            if (bus.pe_stall_any) begin
               cnt_n = '0;
            end else if (cnt_q == LAST_SET) begin
               nxt   = DRAIN;
               row_n = '0;
            end else begin
               cnt_n = cnt_q + SW'(1);
            end
         end
         DRAIN: begin
            if (bus.res_ready) begin
               if (row_q == LAST_ROW) begin
                  nxt = DONE;
               end else begin
                  row_n = row_q + RW'(1);
               end
            end
         end
         DONE: begin
            nxt = IDLE;
            t_n = '0;
         end
         default: nxt = IDLE;
      endcase
   end

   // Registered outputs track the state being entered.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= IDLE;
         t_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         row_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= nxt;
         t_q     <= t_n;
         k_q     <= k_n;
         cnt_q   <= cnt_n;
         row_q   <= row_n;
         ready_q <= (nxt == IDLE);
         busy_q  <= (nxt != IDLE);
         done_q  <= (nxt == DONE);
         valid_q <= (nxt == DRAIN);
      end
   end

   sa_skew_mask #(
      .ARRAY_N (ARRAY_N),
      .TW      (TW),
      .KW      (KW)
   ) u_row_mask (
      .t    (t_q),
      .k    (k_q),
      .en   (feed_en),
      .mask (bus.row_start)
   );

   sa_skew_mask #(
      .ARRAY_N (ARRAY_N),
      .TW      (TW),
      .KW      (KW)
   ) u_col_mask (
      .t    (t_q),
      .k    (k_q),
      .en   (feed_en),
      .mask (bus.col_start)
   );

`ifdef SA_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         perf_q <= '0;
      end else if (accept) begin
         perf_q <= '0;
      end else if ((state == FEED) && bus.pe_stall_any
                   && (perf_q != '1)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign bus.perf_stall_cyc = perf_q;
`else
   assign bus.perf_stall_cyc = '0;
`endif

   assign bus.cmd_ready = ready_q;
   assign bus.acc_clr   = accept;
   assign bus.feed_en   = feed_en;
   assign bus.feed_step = t_q;
   assign bus.res_valid = valid_q;
   assign bus.res_row   = row_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_sa_wavefront_scheduler.sv
// Directed bench for sa_wavefront_scheduler (ARRAY_N=4, K_MAX=64, SETTLE=2).
module tb_sa_wavefront_scheduler;

`ifdef SA_PERF_CNT_EN
   localparam int EXP_PERF = 5;
`else
   localparam int EXP_PERF = 0;
`endif

   logic clk = 1'b0;
   logic n_rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   sa_wavefront_scheduler_if #(.ARRAY_N(4), .K_MAX(64)) bus ();

   sa_wavefront_scheduler #(
      .ARRAY_N (4),
      .K_MAX   (64),
      .SETTLE  (2)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   logic [3:0] m3 [9] = '{4'b0001, 4'b0011, 4'b0111,
                          4'b1110, 4'b1100, 4'b1000,
                          4'b0000, 4'b0000, 4'b0000};
   logic [3:0] m2 [8] = '{4'b0001, 4'b0011, 4'b0110,
                          4'b1100, 4'b1000, 4'b0000,
                          4'b0000, 4'b0000};
   logic       rr [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   int         rows [6] = '{0, 1, 1, 1, 2, 3};

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic finish_tile(input string tag);
      int c;
      c = 0;
      bus.res_ready = 1'b1;
      while (!bus.done && c < 40) begin
         tick();
         c++;
      end
      chk(tag, 32'(bus.done), 32'd1);
      bus.res_ready = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int last;
      int acc;
      logic seen;

      n_rst            = 1'b0;
      bus.cmd_valid    = 1'b1;
      bus.cmd_k        = 7'd3;
      bus.pe_stall_any = 1'b0;
      bus.res_ready    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("rst_acc_clr", 32'(bus.acc_clr), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_res_valid", 32'(bus.res_valid), 0);
      chk("rst_feed_en", 32'(bus.feed_en), 0);
      chk("rst_row_start", 32'(bus.row_start), 0);
      chk("rst_perf", bus.perf_stall_cyc, 0);
      bus.cmd_valid = 1'b0;
      n_rst = 1'b1;
      tick();
      chk("ready_after_rst", 32'(bus.cmd_ready), 1);

      // Test 1: K=3, no stalls, then result walk with toggling ready
      bus.cmd_valid = 1'b1;
      bus.cmd_k     = 7'd3;
      #1;
      chk("t1_acc_clr", 32'(bus.acc_clr), 1);
      tick();
      bus.cmd_valid = 1'b0;
      for (int s = 0; s < 9; s++) begin
         #1;
         if (s == 0) chk("t1_acc_clr_pulse", 32'(bus.acc_clr), 0);
         chk("t1_feed_en", 32'(bus.feed_en), 1);
         chk("t1_step", 32'(bus.feed_step), 32'(s));
         chk("t1_row", 32'(bus.row_start), 32'(m3[s]));
         chk("t1_col", 32'(bus.col_start), 32'(m3[s]));
         tick();
      end
      #1;
      chk("t1_settle0", 32'(bus.res_valid), 0);
      chk("t1_settle_mask", 32'(bus.row_start), 0);
      tick();
      #1;
      chk("t1_settle1", 32'(bus.res_valid), 0);
      tick();
      for (int i = 0; i < 6; i++) begin
         bus.res_ready = rr[i];
         #1;
         chk("t1_res_valid", 32'(bus.res_valid), 1);
         chk("t1_res_row", 32'(bus.res_row), 32'(rows[i]));
         tick();
      end
      bus.res_ready = 1'b0;
      #1;
      chk("t1_done", 32'(bus.done), 1);
      chk("t1_done_valid", 32'(bus.res_valid), 0);
      tick();
      chk("t1_done_pulse", 32'(bus.done), 0);
      chk("t1_idle_busy", 32'(bus.busy), 0);
      chk("t1_idle_ready", 32'(bus.cmd_ready), 1);

      // Test 2: K=3 with a 5-cycle stall at t=2, settle restart
      bus.cmd_valid = 1'b1;
      bus.cmd_k     = 7'd3;
      #1;
      tick();
      bus.cmd_valid = 1'b0;
      for (int s = 0; s < 2; s++) begin
         #1;
         chk("t2_step", 32'(bus.feed_step), 32'(s));
         chk("t2_row", 32'(bus.row_start), 32'(m3[s]));
         tick();
      end
      bus.pe_stall_any = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t2_stall_en", 32'(bus.feed_en), 0);
         chk("t2_stall_step", 32'(bus.feed_step), 2);
         chk("t2_stall_row", 32'(bus.row_start), 0);
         chk("t2_stall_col", 32'(bus.col_start), 0);
         tick();
      end
      bus.pe_stall_any = 1'b0;
      for (int s = 2; s < 9; s++) begin
         #1;
         chk("t2_feed_en", 32'(bus.feed_en), 1);
         chk("t2_step", 32'(bus.feed_step), 32'(s));
         chk("t2_row", 32'(bus.row_start), 32'(m3[s]));
         tick();
      end
      tick();
      bus.pe_stall_any = 1'b1;
      #1;
      chk("t2_settle_b", 32'(bus.res_valid), 0);
      tick();
      bus.pe_stall_any = 1'b0;
      #1;
      chk("t2_settle_c", 32'(bus.res_valid), 0);
      tick();
      #1;
      chk("t2_settle_d", 32'(bus.res_valid), 0);
      tick();
      #1;
      chk("t2_drain", 32'(bus.res_valid), 1);
      bus.res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_res_row", 32'(bus.res_row), 32'(i));
         tick();
      end
      bus.res_ready = 1'b0;
      #1;
      chk("t2_done", 32'(bus.done), 1);
      chk("t2_perf", bus.perf_stall_cyc, 32'(EXP_PERF));
      tick();
      chk("t2_perf_hold", bus.perf_stall_cyc, 32'(EXP_PERF));

      // Test 4: K=0 goes straight to done; oversize K saturates
      bus.cmd_valid = 1'b1;
      bus.cmd_k     = 7'd0;
      #1;
      chk("t4_k0_acc", 32'(bus.acc_clr), 1);
      tick();
      bus.cmd_valid = 1'b0;
      #1;
      chk("t4_k0_done", 32'(bus.done), 1);
      chk("t4_k0_feed", 32'(bus.feed_en), 0);
      chk("t4_k0_busy", 32'(bus.busy), 1);
      tick();
      chk("t4_k0_idle", 32'(bus.cmd_ready), 1);
      chk("t4_k0_pulse", 32'(bus.done), 0);

      bus.cmd_valid = 1'b1;
      bus.cmd_k     = 7'(200);
      #1;
      tick();
      bus.cmd_valid = 1'b0;
      n    = 0;
      last = 0;
      for (int c = 0; c < 200 && !bus.res_valid; c++) begin
         #1;
         if (bus.feed_en) begin
            n++;
            last = 32'(bus.feed_step);
         end
         tick();
      end
      chk("t4_sat_steps", 32'(n), 70);
      chk("t4_sat_last", 32'(last), 69);
      chk("t4_sat_drain", 32'(bus.res_valid), 1);
      finish_tile("t4_sat_done");

      // Test 5: reset mid-tile at t=4, then a clean K=2 tile
      bus.cmd_valid = 1'b1;
      bus.cmd_k     = 7'd5;
      #1;
      tick();
      bus.cmd_valid = 1'b0;
      repeat (4) tick();
      chk("t5_pre_step", 32'(bus.feed_step), 4);
      n_rst = 1'b0;
      #1;
      chk("t5_busy", 32'(bus.busy), 0);
      chk("t5_feed_en", 32'(bus.feed_en), 0);
      chk("t5_row", 32'(bus.row_start), 0);
      chk("t5_col", 32'(bus.col_start), 0);
      chk("t5_step", 32'(bus.feed_step), 0);
      chk("t5_ready", 32'(bus.cmd_ready), 0);
      seen = 1'b0;
      repeat (2) begin
         tick();
         seen = seen | bus.done;
      end
      n_rst = 1'b1;
      repeat (3) begin
         tick();
         seen = seen | bus.done;
      end
      chk("t5_no_done", 32'(seen), 0);
      bus.cmd_valid = 1'b1;
      bus.cmd_k     = 7'd2;
      #1;
      tick();
      bus.cmd_valid = 1'b0;
      for (int s = 0; s < 8; s++) begin
         #1;
         chk("t5_k2_en", 32'(bus.feed_en), 1);
         chk("t5_k2_row", 32'(bus.row_start), 32'(m2[s]));
         chk("t5_k2_col", 32'(bus.col_start), 32'(m2[s]));
         tick();
      end
      #1;
      chk("t5_k2_end", 32'(bus.feed_en), 0);
      finish_tile("t5_k2_done");

      // Test 6: cmd_valid held through a tile
      bus.cmd_valid = 1'b1;
      bus.cmd_k     = 7'd1;
      bus.res_ready = 1'b1;
      acc = 0;
      for (int c = 0; c < 60 && !bus.done; c++) begin
         #1;
         if (bus.acc_clr) acc++;
         tick();
      end
      #1;
      chk("t6_done", 32'(bus.done), 1);
      chk("t6_one_accept", 32'(acc), 1);
      chk("t6_no_acc_done", 32'(bus.acc_clr), 0);
      tick();
      chk("t6_second_acc", 32'(bus.acc_clr), 1);
      tick();
      bus.cmd_valid = 1'b0;
      chk("t6_busy", 32'(bus.busy), 1);
      finish_tile("t6_second_done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
